// File: rtl/step_timing_pkg.sv
// Shared types and constants for the step timing generator.
// Holds the FSM state enum, profile width, profile word indices and a period floor helper.
package step_timing_pkg;

   localparam int PROFILE_W = 32;

   // Profile word order as produced by speed_to_timing: {N, nn, t0, tna, delta}
   localparam int IDX_N     = 0;
   localparam int IDX_NN    = 1;
   localparam int IDX_T0    = 2;
   localparam int IDX_TNA   = 3;
   localparam int IDX_DELTA = 4;
   localparam int NUM_IDX   = 5;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      ACCEL,
      CRUISE,
      DECEL,
      DONE
   } st_t;

   function automatic logic [PROFILE_W-1:0] floor_p(
      input logic [PROFILE_W-1:0] v,
      input logic [PROFILE_W-1:0] lo
   );
      return (v < lo) ? lo : v;
   endfunction

endpackage

// File: rtl/step_timing_generator_timer.sv
// Step pulse timer: one period per load, step high for the first PULSE_W cycles.
// Ports: clk, reset, clr (abort), load, period in; step, expire (last-cycle strobe) out.
module step_pulse_timer
   import step_timing_pkg::*;
#(
   parameter int PULSE_W = 10
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 clr,
   input  logic                 load,
   input  logic [PROFILE_W-1:0] period,
   output logic                 step,
   output logic                 expire
);

   localparam int HW = $clog2(PULSE_W) + 1;

   logic [PROFILE_W-1:0] cnt;
   logic [HW-1:0]        hw;
   logic                 active;

   always_ff @(posedge clk) begin
      if (reset || clr) begin
         cnt    <= '0;
         hw     <= '0;
         active <= 1'b0;
         step   <= 1'b0;
      end else if (load) begin
         // counts P-1 .. 0 so the next load lands exactly P cycles later
         cnt    <= period - 1'b1;
         hw     <= HW'(PULSE_W - 1);
         active <= 1'b1;
         step   <= 1'b1;
      end else begin
         if (active) begin
            if (cnt == '0) active <= 1'b0;
            else           cnt    <= cnt - 1'b1;
         end
         if (hw != '0) hw   <= hw - 1'b1;
         else          step <= 1'b0;
      end
   end

   assign expire = active && (cnt == '0);

endmodule

// File: rtl/step_timing_generator.sv
// Trapezoidal step pulse generator: accel, cruise, decel period schedule per move.
// Ports: clk, reset, start, params_valid, p_* profile in; step, busy, step_cnt, finish out.
module step_timing_generator
   import step_timing_pkg::*;
#(
   parameter int PULSE_W    = 10,
   parameter int MIN_PERIOD = 20
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic                 params_valid,
   input  logic [PROFILE_W-1:0] p_num,
   input  logic [PROFILE_W-1:0] p_nn,
   input  logic [PROFILE_W-1:0] p_t0,
   input  logic [PROFILE_W-1:0] p_tna,
   input  logic [PROFILE_W-1:0] p_delta,
   output logic                 step,
   output logic                 busy,
   output logic [PROFILE_W-1:0] step_cnt,
   output logic                 finish
);

   localparam int W = PROFILE_W;
   localparam logic [W-1:0] PMIN = W'(MIN_PERIOD);

   st_t          state, state_n, ph;
   logic [W-1:0] prof [NUM_IDX];
   logic [W-1:0] t_cur, uf, rem, rem_n;
   logic [W-1:0] n_up, n_cr, t_src, uf_src;
   logic [W-1:0] cur_p, cr_p, acc_t, acc_uf;
   logic [W-1:0] dec_t, dec_uf, dec_p, period;
   logic [W:0]   dec_sum;
   logic         ld, adv, expire;

   assign n_up = (prof[IDX_NN] < (prof[IDX_N] >> 1)) ?
                 prof[IDX_NN] : (prof[IDX_N] >> 1);
   assign n_cr = prof[IDX_N] - (n_up << 1);

   // t_cur starts at t0 in LOAD. uf counts accel steps that would have
   // gone below zero; while non-zero the period sits at the floor and
   // decel unwinds uf first so the ramp stays a mirror image.
   assign t_src  = (state == LOAD) ? prof[IDX_T0] : t_cur;
   assign uf_src = (state == LOAD) ? '0 : uf;
   assign cur_p  = (uf_src != '0) ? PMIN : floor_p(t_src, PMIN);
   assign cr_p   = (n_up == prof[IDX_NN]) ?
                   floor_p(prof[IDX_TNA], PMIN) : cur_p;

   always_comb begin
      acc_t  = t_src;
      acc_uf = uf_src;
      if (uf_src != '0 || t_src < prof[IDX_DELTA])
         acc_uf = uf_src + 1'b1;
      else
         acc_t = t_src - prof[IDX_DELTA];
   end

   always_comb begin
      dec_sum = {1'b0, t_src} + {1'b0, prof[IDX_DELTA]};
      dec_t   = t_src;
      dec_uf  = uf_src;
      if (uf_src != '0)
         dec_uf = uf_src - 1'b1;
      else
         dec_t = dec_sum[W] ? '1 : dec_sum[W-1:0];
      dec_p = (dec_uf != '0) ? PMIN : floor_p(dec_t, PMIN);
   end

   always_comb begin
      state_n = state;
      ld      = 1'b0;
      adv     = 1'b0;
      ph      = ACCEL;
      rem_n   = rem;
      unique case (state)
         IDLE:
            if (start && params_valid) state_n = LOAD;
         LOAD:
            if (!start) state_n = IDLE;
            else        adv     = 1'b1;
         ACCEL, CRUISE, DECEL:
            if (!start) begin
               state_n = IDLE;
            end else if (expire) begin
               if (rem != '0) begin
                  ld    = 1'b1;
                  ph    = state;
                  rem_n = rem - 1'b1;
               end else begin
                  adv = 1'b1;
               end
            end
         DONE:
            if (!start) state_n = IDLE;
         default:
            state_n = IDLE;
      endcase
      // next non-empty phase after the current one
      if (adv) begin
         if (state < ACCEL && n_up != '0) begin
            ld = 1'b1; ph = ACCEL; rem_n = n_up - 1'b1;
            state_n = ACCEL;
         end else if (state < CRUISE && n_cr != '0) begin
            ld = 1'b1; ph = CRUISE; rem_n = n_cr - 1'b1;
            state_n = CRUISE;
         end else if (state < DECEL && n_up != '0) begin
            ld = 1'b1; ph = DECEL; rem_n = n_up - 1'b1;
            state_n = DECEL;
         end else begin
            state_n = DONE;
         end
      end
   end

   assign period = (ph == ACCEL)  ? cur_p :
                   (ph == CRUISE) ? cr_p  : dec_p;

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         t_cur    <= '0;
         uf       <= '0;
         rem      <= '0;
         step_cnt <= '0;
         for (int i = 0; i < NUM_IDX; i++) prof[i] <= '0;
      end else begin
         state <= state_n;
         if (state == IDLE && state_n == LOAD) begin
            prof[IDX_N]     <= p_num;
            prof[IDX_NN]    <= p_nn;
            prof[IDX_T0]    <= p_t0;
            prof[IDX_TNA]   <= p_tna;
            prof[IDX_DELTA] <= p_delta;
            step_cnt        <= '0;
         end
         if (state == LOAD) begin
            t_cur <= prof[IDX_T0];
            uf    <= '0;
         end
         if (ld) begin
            rem      <= rem_n;
            step_cnt <= step_cnt + 1'b1;
            if (ph == ACCEL) begin
               t_cur <= acc_t;
               uf    <= acc_uf;
            end else if (ph == DECEL) begin
               t_cur <= dec_t;
               uf    <= dec_uf;
            end
         end
      end
   end

   assign busy   = (state == LOAD) || (state == ACCEL) ||
                   (state == CRUISE) || (state == DECEL);
   assign finish = (state == DONE);

   step_pulse_timer #(
      .PULSE_W (PULSE_W)
   ) u_timer (
      .clk    (clk),
      .reset  (reset),
      .clr    (!start),
      .load   (ld),
      .period (period),
      .step   (step),
      .expire (expire)
   );

endmodule

// File: tb/tb_step_timing_generator.sv
// Self-checking bench for step_timing_generator.
// Expected step periods are queued per move and checked as step edges arrive.
module tb_step_timing_generator;

   localparam int PW   = 10;
   localparam int MINP = 20;

   logic        clk = 1'b0;
   logic        reset, start, params_valid;
   logic [31:0] p_num, p_nn, p_t0, p_tna, p_delta;
   logic        step, busy, finish;
   logic [31:0] step_cnt;

   always #5 clk = ~clk;

   step_timing_generator #(
      .PULSE_W    (PW),
      .MIN_PERIOD (MINP)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .params_valid (params_valid),
      .p_num        (p_num),
      .p_nn         (p_nn),
      .p_t0         (p_t0),
      .p_tna        (p_tna),
      .p_delta      (p_delta),
      .step         (step),
      .busy         (busy),
      .step_cnt     (step_cnt),
      .finish       (finish)
   );

   int          total = 0;
   int          bad = 0;
   int unsigned sb_q[$];
   longint      cyc = 0;
   longint      last_rise = 0, first_rise = 0, fin_cyc = 0;
   int          rises = 0;
   bit          have_last = 0;
   logic        prev_step = 1'b0, prev_fin = 1'b0;
   int unsigned m_per, m_exp;

   always @(posedge clk) cyc <= cyc + 1;

   // scoreboard: each rising step edge (and the finish edge) closes a period
   always @(negedge clk) begin
      if (step && !prev_step) begin
         rises++;
         if (have_last) begin
            m_per = 32'(cyc - last_rise);
            total++;
            if (sb_q.size() == 0) begin
               bad++;
               $display("FAIL sb_extra: got period %0d, none expected", m_per);
            end else begin
               m_exp = sb_q.pop_front();
               if (m_per !== m_exp) begin
                  bad++;
                  $display("FAIL sb_period: got %0d want %0d", m_per, m_exp);
               end
            end
         end else begin
            first_rise = cyc;
         end
         have_last = 1;
         last_rise = cyc;
      end
      if (finish && !prev_fin) begin
         fin_cyc = cyc;
         if (have_last) begin
            m_per = 32'(cyc - last_rise);
            total++;
            if (sb_q.size() == 0) begin
               bad++;
               $display("FAIL sb_extra_last: got period %0d, none expected", m_per);
            end else begin
               m_exp = sb_q.pop_front();
               if (m_per !== m_exp) begin
                  bad++;
                  $display("FAIL sb_last_period: got %0d want %0d", m_per, m_exp);
               end
            end
         end
         have_last = 0;
      end
      if (!busy && !finish) have_last = 0;
      prev_step = step;
      prev_fin  = finish;
   end

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic settle();
      @(negedge clk);
      #1;
   endtask

   task automatic set_prof(input int unsigned n, nn, t0, tna, d);
      p_num = n; p_nn = nn; p_t0 = t0; p_tna = tna; p_delta = d;
   endtask

   task automatic wait_fin(input int budget, output bit ok);
      ok = 0;
      for (int i = 0; i < budget; i++) begin
         tick();
         if (finish) begin
            ok = 1;
            break;
         end
      end
   endtask

   task automatic wait_cnt(input int k, input int budget, output bit ok);
      ok = 0;
      for (int i = 0; i < budget; i++) begin
         tick();
         if (step_cnt == 32'(k) && step) begin
            ok = 1;
            break;
         end
      end
   endtask

   task automatic push_list(input int unsigned l[$]);
      foreach (l[i]) sb_q.push_back(l[i]);
   endtask

   task automatic test_reset();
      reset = 1; start = 0; params_valid = 0;
      set_prof(0, 0, 0, 0, 0);
      tick(3);
      total++;
      if (step !== 1'b0) begin bad++; $display("FAIL rst_step: got %b want 0", step); end
      total++;
      if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
      total++;
      if (finish !== 1'b0) begin bad++; $display("FAIL rst_finish: got %b want 0", finish); end
      total++;
      if (step_cnt !== 32'd0) begin bad++; $display("FAIL rst_cnt: got %0d want 0", step_cnt); end
      reset = 0;
      tick();
   endtask

   task automatic test_profile();
      bit ok;
      set_prof(10, 3, 100, 70, 10);
      params_valid = 1;
      push_list('{100, 90, 80, 70, 70, 70, 70, 80, 90, 100});
      start = 1;
      wait_cnt(5, 2000, ok);
      total++;
      if (!ok) begin bad++; $display("FAIL prof_reach5: got timeout want step 5"); end
      total++;
      if (busy !== 1'b1) begin bad++; $display("FAIL prof_busy: got %b want 1", busy); end
      // inputs change mid-move; schedule must not follow them
      set_prof(3, 0, 999, 33, 1);
      params_valid = 0;
      wait_fin(2000, ok);
      settle();
      total++;
      if (!ok) begin bad++; $display("FAIL prof_finish: got timeout want finish"); end
      total++;
      if (step_cnt !== 32'd10) begin bad++; $display("FAIL prof_cnt: got %0d want 10", step_cnt); end
      total++;
      if (busy !== 1'b0) begin bad++; $display("FAIL prof_busy_done: got %b want 0", busy); end
      total++;
      if (fin_cyc - first_rise !== 64'd820) begin
         bad++;
         $display("FAIL prof_len: got %0d want 820", fin_cyc - first_rise);
      end
      total++;
      if (sb_q.size() !== 0) begin bad++; $display("FAIL prof_sb_left: got %0d want 0", sb_q.size()); end
      start = 0;
      tick();
      total++;
      if (finish !== 1'b0) begin bad++; $display("FAIL prof_fin_clr: got %b want 0", finish); end
   endtask

   task automatic test_short();
      bit ok;
      params_valid = 1;
      set_prof(5, 3, 100, 70, 10);
      push_list('{100, 90, 80, 90, 100});
      start = 1;
      wait_fin(2000, ok);
      settle();
      total++;
      if (!ok || step_cnt !== 32'd5) begin
         bad++;
         $display("FAIL short5_cnt: got %0d want 5 (finish %b)", step_cnt, ok);
      end
      start = 0;
      tick();
      set_prof(4, 3, 100, 70, 10);
      push_list('{100, 90, 90, 100});
      start = 1;
      wait_fin(2000, ok);
      settle();
      total++;
      if (!ok || step_cnt !== 32'd4) begin
         bad++;
         $display("FAIL short4_cnt: got %0d want 4 (finish %b)", step_cnt, ok);
      end
      total++;
      if (sb_q.size() !== 0) begin bad++; $display("FAIL short_sb_left: got %0d want 0", sb_q.size()); end
      start = 0;
      tick();
   endtask

   task automatic test_zero_one();
      bit ok;
      int r0;
      params_valid = 1;
      set_prof(0, 3, 100, 70, 10);
      r0 = rises;
      start = 1;
      tick();
      total++;
      if (finish !== 1'b0 || busy !== 1'b1) begin
         bad++;
         $display("FAIL zero_load: got finish=%b busy=%b want 0/1", finish, busy);
      end
      tick();
      total++;
      if (finish !== 1'b1) begin bad++; $display("FAIL zero_finish: got %b want 1", finish); end
      total++;
      if (rises !== r0 || step_cnt !== 32'd0) begin
         bad++;
         $display("FAIL zero_nostep: got rises=%0d cnt=%0d want %0d/0", rises, step_cnt, r0);
      end
      start = 0;
      tick();
      set_prof(1, 3, 100, 70, 10);
      push_list('{100});
      start = 1;
      wait_fin(2000, ok);
      settle();
      total++;
      if (!ok || step_cnt !== 32'd1) begin
         bad++;
         $display("FAIL one_cnt: got %0d want 1 (finish %b)", step_cnt, ok);
      end
      total++;
      if (sb_q.size() !== 0) begin bad++; $display("FAIL one_sb_left: got %0d want 0", sb_q.size()); end
      start = 0;
      tick();
   endtask

   task automatic test_clamp();
      bit ok;
      params_valid = 1;
      set_prof(8, 4, 50, 200, 20);
      push_list('{50, 30, 20, 20, 20, 20, 30, 50});
      start = 1;
      wait_fin(2000, ok);
      settle();
      total++;
      if (!ok || step_cnt !== 32'd8) begin
         bad++;
         $display("FAIL clamp_cnt: got %0d want 8 (finish %b)", step_cnt, ok);
      end
      total++;
      if (sb_q.size() !== 0) begin bad++; $display("FAIL clamp_sb_left: got %0d want 0", sb_q.size()); end
      start = 0;
      tick();
   endtask

   task automatic test_abort();
      bit ok;
      params_valid = 1;
      set_prof(10, 3, 100, 70, 10);
      push_list('{100, 90});
      start = 1;
      wait_cnt(3, 2000, ok);
      total++;
      if (!ok) begin bad++; $display("FAIL abort_reach3: got timeout want step 3"); end
      start = 0;
      tick();
      total++;
      if (step !== 1'b0 || busy !== 1'b0 || finish !== 1'b0) begin
         bad++;
         $display("FAIL abort_out: got step=%b busy=%b fin=%b want 0/0/0", step, busy, finish);
      end
      total++;
      if (step_cnt !== 32'd3) begin bad++; $display("FAIL abort_cnt: got %0d want 3", step_cnt); end
      total++;
      if (sb_q.size() !== 0) begin bad++; $display("FAIL abort_sb_left: got %0d want 0", sb_q.size()); end
      tick(2);
      push_list('{100, 90, 80, 70, 70, 70, 70, 80, 90, 100});
      start = 1;
      wait_fin(2000, ok);
      settle();
      total++;
      if (!ok || step_cnt !== 32'd10) begin
         bad++;
         $display("FAIL restart_cnt: got %0d want 10 (finish %b)", step_cnt, ok);
      end
      total++;
      if (sb_q.size() !== 0) begin bad++; $display("FAIL restart_sb_left: got %0d want 0", sb_q.size()); end
      start = 0;
      tick();
   endtask

   task automatic test_reset_mid();
      bit ok;
      params_valid = 1;
      set_prof(10, 3, 100, 70, 10);
      push_list('{100});
      start = 1;
      wait_cnt(2, 2000, ok);
      tick(3);
      total++;
      if (!ok || step !== 1'b1) begin
         bad++;
         $display("FAIL rmid_pulse: got step=%b ok=%b want 1/1", step, ok);
      end
      reset = 1;
      tick();
      total++;
      if (step !== 1'b0 || busy !== 1'b0 || finish !== 1'b0 || step_cnt !== 32'd0) begin
         bad++;
         $display("FAIL rmid_out: got step=%b busy=%b fin=%b cnt=%0d want 0/0/0/0",
                  step, busy, finish, step_cnt);
      end
      reset = 0;
      start = 0;
      tick();
      total++;
      if (sb_q.size() !== 0) begin bad++; $display("FAIL rmid_sb_left: got %0d want 0", sb_q.size()); end
   endtask

   task automatic test_model();
      bit ok;
      int unsigned n, nn, t0, tna, d, nup, ncr;
      longint v;
      int unsigned acc[$];
      params_valid = 1;
      for (int it = 0; it < 4; it++) begin
         n   = $urandom_range(0, 12);
         nn  = $urandom_range(0, 6);
         t0  = $urandom_range(20, 150);
         tna = $urandom_range(15, 120);
         d   = $urandom_range(0, 40);
         set_prof(n, nn, t0, tna, d);
         nup = (nn < n / 2) ? nn : n / 2;
         ncr = n - 2 * nup;
         acc.delete();
         for (int k = 0; k < int'(nup); k++) begin
            v = longint'(t0) - longint'(k) * longint'(d);
            acc.push_back((v < MINP) ? MINP : int'(v));
         end
         v = (nup == nn) ? longint'(tna) : longint'(t0) - longint'(nup) * longint'(d);
         if (v < MINP) v = MINP;
         foreach (acc[i]) sb_q.push_back(acc[i]);
         for (int k = 0; k < int'(ncr); k++) sb_q.push_back(int'(v));
         for (int k = int'(nup) - 1; k >= 0; k--) sb_q.push_back(acc[k]);
         start = 1;
         wait_fin(5000, ok);
         settle();
         total++;
         if (!ok || step_cnt !== n) begin
            bad++;
            $display("FAIL model_cnt%0d: got %0d want %0d (finish %b)", it, step_cnt, n, ok);
         end
         total++;
         if (sb_q.size() !== 0) begin
            bad++;
            $display("FAIL model_sb_left%0d: got %0d want 0", it, sb_q.size());
            sb_q.delete();
         end
         start = 0;
         tick();
      end
   endtask

   initial begin
      test_reset();
      test_profile();
      test_short();
      test_zero_one();
      test_clamp();
      test_abort();
      test_reset_mid();
      test_model();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
